// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmit path. A DEPTH-entry synchronous FIFO fed by the
//            APB FIFO slave, a bit-period divider and an 8N1 serializer that
//            drains the FIFO onto tx, LSB first, with back-to-back frames.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     TX_wr,
    input  logic [7:0]               TX_wdata,
    output logic                     TX_full,
    output logic                     TX_empty,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_busy,
    output logic                     tx_ovf,
    output logic                     tx
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_pop;
    logic [7:0]    w_rdata;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          w_div_last;

    assign w_full   = (count_q == FULL_CNT);
    assign w_empty  = (count_q == '0);
    // Fullness is taken before the edge, so a same-cycle pop never rescues a write.
    assign w_wr_acc = TX_wr & ~w_full;
    assign w_rdata  = mem_q[rptr_q];

    // FIFO pointer, occupancy and overflow next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = TX_wr & w_full;
        if (w_wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({w_wr_acc, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO data array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wptr_q] <= TX_wdata;
        end
    end

    assign w_div_last = (div_q == DIV_LAST);

    // Serializer next-state, divider, shifter and line value
    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                tx_d  = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_rdata;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (w_div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (w_div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift so the next bit to send always sits in [1] here.
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (w_div_last) begin
                    div_d = '0;
                    if (!w_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        w_pop   = 1'b1;
                        shift_d = w_rdata;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign TX_full  = w_full;
    assign TX_empty = w_empty;
    assign tx_count = count_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_ovf   = ovf_q;
    assign tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo. A timeline model (byte
//            queue plus frame start time) predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          TX_wr = 1'b0;
    logic [7:0]    TX_wdata = 8'h00;
    logic          TX_full;
    logic          TX_empty;
    logic [CW-1:0] tx_count;
    logic          tx_busy;
    logic          tx_ovf;
    logic          tx;

    int vecs  = 0;
    int fails = 0;

    uart_tx_fifo #(
        .DEPTH    (DEPTH),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .TX_wr    (TX_wr),
        .TX_wdata (TX_wdata),
        .TX_full  (TX_full),
        .TX_empty (TX_empty),
        .tx_count (tx_count),
        .tx_busy  (tx_busy),
        .tx_ovf   (tx_ovf),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    wire [CW+4:0] dut_vec = {tx, tx_busy, tx_ovf, TX_full, TX_empty, tx_count};

    // Reference model: pending bytes, whether a frame is on the line, when it began.
    logic [7:0] m_q[$];
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_fstart = 0;
    logic [7:0] m_byte = 8'h00;
    int         m_t = 0;

    function automatic logic m_tx_bit();
        int idx;
        if (!m_busy) return 1'b1;
        idx = (m_t - m_fstart) / DIV;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    function automatic logic [CW+4:0] m_vec();
        logic f, e;
        f = (m_q.size() == DEPTH);
        e = (m_q.size() == 0);
        return {m_tx_bit(), logic'(m_busy), logic'(m_ovf), f, e, CW'(m_q.size())};
    endfunction

    // Expected line level for a run of back-to-back frames starting at cycle s0
    function automatic logic frame_level(input int c, input int s0, input logic [7:0] b);
        int off;
        off = c - s0;
        if (off < DIV) return 1'b0;
        if (off < 9 * DIV) return b[(off - DIV) / DIV];
        return 1'b1;
    endfunction

    // Drive one cycle of inputs, advance the clock and the model together.
    task automatic tick(input logic r, input logic w, input logic [7:0] d);
        bit         pop, fend, full;
        logic [7:0] pb;
        pb = 8'h00;
        rst = r; TX_wr = w; TX_wdata = d;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            fend  = m_busy && (m_t == m_fstart + FRAME - 1);
            full  = (m_q.size() == DEPTH);
            pop   = (m_q.size() != 0) && (!m_busy || fend);
            m_ovf = w && full;
            if (pop) pb = m_q.pop_front();
            if (w && !full) m_q.push_back(d);
            if (pop) begin
                m_busy   = 1'b1;
                m_fstart = m_t + 1;
                m_byte   = pb;
            end else if (fend) begin
                m_busy = 1'b0;
            end
        end
        m_t++;
        #1;
        rst = 1'b0; TX_wr = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        vecs++; if (tx !== 1'b1)       begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
        vecs++; if (TX_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", TX_empty); end
        vecs++; if (TX_full !== 1'b0)  begin fails++; $display("FAIL reset_full got=%b exp=0", TX_full); end
        vecs++; if (tx_count !== '0)   begin fails++; $display("FAIL reset_count got=%0d exp=0", tx_count); end
        vecs++; if (tx_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        vecs++; if (tx_ovf !== 1'b0)   begin fails++; $display("FAIL reset_ovf got=%b exp=0", tx_ovf); end
        vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL reset_model got=%b exp=%b", dut_vec, m_vec()); end
    endtask

    task automatic test_single();
        logic e;
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c <= 110; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL single_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            e = (c < 2 || c > 101) ? 1'b1 : frame_level(c, 2, 8'hA5);
            vecs++; if (tx !== e) begin fails++; $display("FAIL single_tx c=%0d got=%b exp=%b", c, tx, e); end
            if (c == 1) begin
                vecs++; if (tx_count !== CW'(1)) begin fails++; $display("FAIL single_count1 got=%0d exp=1", tx_count); end
            end
            if (c == 2) begin
                vecs++; if (tx_count !== CW'(0)) begin fails++; $display("FAIL single_count2 got=%0d exp=0", tx_count); end
            end
            if (c >= 102) begin
                vecs++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL single_busy c=%0d got=%b exp=0", c, tx_busy); end
            end
            tick(1'b0, c == 0, 8'hA5);
        end
    endtask

    task automatic test_fill_overflow();
        int         fs, nrx;
        logic [7:0] rx;
        fs = -1; nrx = 0; rx = 8'h00;
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c <= 17 * FRAME + 20; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL fill_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            vecs++; if (tx_ovf !== (c == 18)) begin fails++; $display("FAIL fill_ovf c=%0d got=%b exp=%b", c, tx_ovf, (c == 18)); end
            if (c == 17) begin
                vecs++; if (tx_count !== CW'(16) || TX_full !== 1'b1) begin
                    fails++; $display("FAIL fill_full count=%0d full=%b exp=16/1", tx_count, TX_full);
                end
            end
            // Line decoder: sample each bit mid-period
            if (fs < 0 && tx === 1'b0) fs = c;
            if (fs >= 0) begin
                for (int i = 0; i < 8; i++)
                    if (c == fs + DIV * (i + 1) + DIV / 2) rx[i] = tx;
                if (c == fs + FRAME - 1) begin
                    vecs++; if (rx !== 8'(nrx)) begin fails++; $display("FAIL fill_byte idx=%0d got=%02h exp=%02h", nrx, rx, 8'(nrx)); end
                    nrx++;
                    fs = -1;
                end
            end
            if (c <= 16)      tick(1'b0, 1'b1, 8'(c));
            else if (c == 17) tick(1'b0, 1'b1, 8'hFF);
            else              tick(1'b0, 1'b0, 8'h00);
        end
        vecs++; if (nrx !== 17) begin fails++; $display("FAIL fill_nframes got=%0d exp=17", nrx); end
    endtask

    task automatic test_back_to_back();
        logic e;
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c <= 210; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL b2b_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            if (c < 2 || c > 201) e = 1'b1;
            else if (c < 102)     e = frame_level(c, 2, 8'h55);
            else                  e = frame_level(c, 102, 8'h0F);
            vecs++; if (tx !== e) begin fails++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, tx, e); end
            vecs++; if (tx_busy !== (c >= 2 && c <= 201)) begin fails++; $display("FAIL b2b_busy c=%0d got=%b", c, tx_busy); end
            if (c >= 103) begin
                vecs++; if (TX_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty c=%0d got=%b exp=1", c, TX_empty); end
            end
            tick(1'b0, c <= 1, (c == 0) ? 8'h55 : 8'h0F);
        end
    endtask

    task automatic test_reset_midframe();
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c <= 260; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL midrst_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            if (c >= 51) begin
                vecs++; if (tx !== 1'b1 || tx_count !== '0 || TX_empty !== 1'b1 || tx_busy !== 1'b0) begin
                    fails++; $display("FAIL midrst_idle c=%0d tx=%b count=%0d empty=%b busy=%b", c, tx, tx_count, TX_empty, tx_busy);
                end
            end
            if (c == 50)     tick(1'b1, 1'b0, 8'h00);
            else if (c == 0) tick(1'b0, 1'b1, 8'hFF);
            else if (c <= 3) tick(1'b0, 1'b1, 8'($urandom));
            else             tick(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_simul_wr_pop();
        logic [7:0] b [3];
        logic       e;
        int         fr;
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c <= 310; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL simul_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            if (c < 2 || c > 301) e = 1'b1;
            else begin
                fr = (c - 2) / FRAME;
                e  = frame_level(c, 2 + fr * FRAME, b[fr]);
            end
            vecs++; if (tx !== e) begin fails++; $display("FAIL simul_tx c=%0d got=%b exp=%b", c, tx, e); end
            if (c == 101 || c == 102) begin
                vecs++; if (tx_count !== CW'(1)) begin fails++; $display("FAIL simul_count c=%0d got=%0d exp=1", c, tx_count); end
            end
            if (c == 0)        tick(1'b0, 1'b1, b[0]);
            else if (c == 5)   tick(1'b0, 1'b1, b[1]);
            else if (c == 101) tick(1'b0, 1'b1, b[2]);
            else               tick(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_random();
        int  pct;
        bit  r, w;
        tick(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 4000; c++) begin
            vecs++; if (dut_vec !== m_vec()) begin fails++; $display("FAIL random_model c=%0d got=%b exp=%b", c, dut_vec, m_vec()); end
            case ((c / 500) % 4)
                0:       pct = 2;
                1:       pct = 15;
                2:       pct = 60;
                default: pct = 0;
            endcase
            r = ($urandom_range(0, 1499) == 0);
            w = ($urandom_range(0, 99) < pct);
            tick(r, w, 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_simul_wr_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit half of the UART peripheral: buffered TX path that consumes the APB FIFO slave's write strobe and data byte (TX_wr/TX_wdata) and reports TX_full back to it.
Contains a DEPTH-entry synchronous FIFO, a bit-period divider and an 8N1 serializer that drains the FIFO onto the tx pin, LSB first, with back-to-back frames and no idle gap.
Sits between the APB FIFO slave interface and the board tx pin.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
CLK_FREQ, 100_000_000, clk frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD clocks per bit (integer division), DIV at least 2

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
TX_wr  in  1  single-cycle write strobe from APB slave
TX_wdata  in  8  byte to enqueue, valid when TX_wr=1
TX_full  out  1  FIFO holds DEPTH entries
TX_empty  out  1  FIFO holds 0 entries
tx_count  out  $clog2(DEPTH)+1  current FIFO occupancy
tx_busy  out  1  serializer not in IDLE
tx_ovf  out  1  one-cycle pulse: a write was dropped because FIFO full
tx  out  1  serial line, idle high, registered

Behaviour:
- Reset (rst=1 at posedge): pointers and count to 0, TX_empty=1, TX_full=0, tx=1, tx_busy=0, tx_ovf=0, state=IDLE, divider and bit counter to 0. FIFO contents are discarded.
- Reset mid-frame: tx returns high on the next cycle and no residual bits follow.
- FIFO write: accepted at a posedge when TX_wr=1 and TX_full=0 (value of TX_full before that edge). mem[wptr] gets TX_wdata, wptr wraps modulo DEPTH.
- Dropped write: TX_wr=1 with TX_full=1 leaves FIFO state unchanged; tx_ovf=1 for exactly the next cycle. A pop in the same cycle does not rescue the write.
- FIFO pop: only the serializer issues it, only when TX_empty=0. Read is combinational from mem[rptr]; rptr wraps modulo DEPTH.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- TX_full = (count==DEPTH); TX_empty = (count==0). Both are derived from the registered count, with no extra latency.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if TX_empty=0, pop, load shift register, go to START, tx<=0, clear divider. Otherwise hold tx=1.
  - START: tx=0 for DIV cycles, then go to DATA, tx<=shift[0], bit index 0.
  - DATA: each bit lasts DIV cycles, LSB first. After bit 7, go to STOP, tx<=1.
  - STOP: tx=1 for DIV cycles. On the final cycle, if TX_empty=0, pop and go directly to START (tx<=0, no gap). Otherwise go to IDLE.
- Divider: counts 0..DIV-1 and is cleared on every state entry, so every bit is exactly DIV cycles long.
- tx_busy = (state != IDLE).
- Latency: TX_wr high in cycle 0 into an empty idle block gives count=1 in cycle 1, pop at end of cycle 1, tx=0 from cycle 2. One frame is 10*DIV cycles.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), DEPTH=16.
1. Reset: hold rst for 3 cycles -> tx=1, TX_empty=1, TX_full=0, tx_count=0, tx_busy=0, tx_ovf=0.
2. Single byte 0xA5 written in cycle 0 -> tx_count=1 in cycle 1 and 0 in cycle 2; tx=0 during cycles 2-11; data bits 1,0,1,0,0,1,0,1 each 10 cycles (cycles 12-91); tx=1 stop during 92-101; tx_busy=0 from cycle 102.
3. Fill and overflow: write 0x00..0x10 in cycles 0-16, then 0xFF in cycle 17 -> 0x00 popped at end of cycle 1; tx_count=16 and TX_full=1 in cycle 17; 0xFF dropped; tx_ovf=1 only in cycle 18; line carries 0x00..0x10 in order, never 0xFF.
4. Back-to-back: write 0x55 in cycle 0 and 0x0F in cycle 1 -> second start bit begins at cycle 102, immediately after the first stop bit, with no idle cycle; TX_empty=1 from cycle 103; tx_busy stays 1 until cycle 202.
5. Reset mid-frame: write 0xFF, then three more bytes; assert rst in cycle 50 (during DATA) -> from cycle 51 tx=1, tx_count=0, TX_empty=1, tx_busy=0; after rst deasserts, tx stays 1 for at least 200 cycles.
6. Simultaneous write and pop: with count=1 and the serializer at the final STOP cycle, assert TX_wr=1 in that cycle -> tx_count stays 1, the next START begins with the older byte, and the new byte follows as the frame after.
